// File: rtl/mult_dispatch_pkg.sv
// Shared types for the multiplier dispatcher: FSM states, operand pair, sizing defaults.
// Zero-operand bypass is compiled in with MULT_DISPATCH_ZERO_BYPASS_EN.
package mult_dispatch_pkg;

   localparam int MUL_W      = 16;
   localparam int FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   typedef struct packed {
      logic [MUL_W-1:0] a;
      logic [MUL_W-1:0] b;
   } operand_t;

   // A pair with either operand zero has a known zero product.
   function automatic logic has_zero_operand(input operand_t op);
      return (op.a == {MUL_W{1'b0}}) || (op.b == {MUL_W{1'b0}});
   endfunction

endpackage

// File: rtl/mult_dispatch_fifo.sv
// Operand-pair FIFO for the dispatcher: registered storage, no empty bypass,
// push refused while full regardless of a same-cycle pop.
module mult_dispatch_fifo
   import mult_dispatch_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  operand_t                 push_data,
   input  logic                     pop,
   output operand_t                 pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   operand_t        mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [AW:0]     count_r;
   logic            do_push_s;
   logic            do_pop_s;

   assign full      = (count_r == CNT_FULL);
   assign empty     = (count_r == '0);
   assign count     = count_r;
   assign pop_data  = mem_r[rd_ptr_r];
   assign do_push_s = push && !full;
   assign do_pop_s  = pop && !empty;

   // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/mult_dispatch.sv
// Sequencer in front of the shift-add multiplier: buffers operand pairs, issues one start
// per pair, returns products in order. Define MULT_DISPATCH_ZERO_BYPASS_EN to skip zero pairs.
module mult_dispatch
   import mult_dispatch_pkg::*;
#(
   parameter int W     = MUL_W,
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [W-1:0]             in_a,
   input  logic [W-1:0]             in_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2*W-1:0]           out_result,
   output logic                     mul_start,
   output logic [W-1:0]             mul_a,
   output logic [W-1:0]             mul_b,
   input  logic                     mul_ready,
   input  logic [2*W-1:0]           mul_result,
   output logic [$clog2(DEPTH):0]   occupancy
);

   state_t            state_r;
   logic              mul_start_r;
   logic [W-1:0]      mul_a_r;
   logic [W-1:0]      mul_b_r;
   logic              out_valid_r;
   logic [2*W-1:0]    out_result_r;
   operand_t          wr_data_s;
   operand_t          head_s;
   logic              full_s;
   logic              empty_s;
   logic              push_s;
   logic              pop_s;

   assign in_ready    = !full_s;
   assign push_s      = in_valid && !full_s;
   assign pop_s       = (state_r == IDLE) && !empty_s;
   assign wr_data_s.a = in_a;
   assign wr_data_s.b = in_b;

   assign mul_start   = mul_start_r;
   assign mul_a       = mul_a_r;
   assign mul_b       = mul_b_r;
   assign out_valid   = out_valid_r;
   assign out_result  = out_result_r;

   mult_dispatch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_s),
      .push_data (wr_data_s),
      .pop       (pop_s),
      .pop_data  (head_s),
      .full      (full_s),
      .empty     (empty_s),
      .count     (occupancy)
   );

   // Dispatch FSM; mul_ready only matters in WAIT, so a stale done level after reset is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         mul_start_r  <= 1'b0;
         mul_a_r      <= '0;
         mul_b_r      <= '0;
         out_valid_r  <= 1'b0;
         out_result_r <= '0;
      end else begin
         mul_start_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (!empty_s) begin
                  mul_a_r <= head_s.a;
                  mul_b_r <= head_s.b;
`ifdef MULT_DISPATCH_ZERO_BYPASS_EN
                  if (has_zero_operand(head_s)) begin
                     out_result_r <= '0;
                     out_valid_r  <= 1'b1;
                     state_r      <= HOLD;
                  end else begin
                     mul_start_r <= 1'b1;
                     state_r     <= ISSUE;
                  end
`else
                  mul_start_r <= 1'b1;
                  state_r     <= ISSUE;
`endif
               end
            end
            ISSUE: begin
               state_r <= WAIT;
            end
            WAIT: begin
               if (mul_ready) begin
                  out_result_r <= mul_result;
                  out_valid_r  <= 1'b1;
                  state_r      <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  state_r     <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_dispatch.sv
// Self-checking bench for mult_dispatch with a behavioural multiplier and a product scoreboard.
module tb_mult_dispatch;

   localparam int W     = 16;
   localparam int DEPTH = 4;

   localparam logic [15:0] TA [4] = '{16'hFFFF, 16'h0002, 16'h0100, 16'h0001};
   localparam logic [15:0] TB [4] = '{16'hFFFF, 16'h0003, 16'h0100, 16'hFFFF};
   localparam logic [31:0] TE [4] = '{32'hFFFE0001, 32'h00000006, 32'h00010000, 32'h0000FFFF};

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [W-1:0]      in_a = '0;
   logic [W-1:0]      in_b = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [2*W-1:0]    out_result;
   logic              mul_start;
   logic [W-1:0]      mul_a;
   logic [W-1:0]      mul_b;
   logic              mul_ready = 1'b0;
   logic [2*W-1:0]    mul_result = '0;
   logic [2:0]        occupancy;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   int push_cnt = 0;
   int lat_cfg = 0;
   int m_cnt = 0;
   logic m_busy = 1'b0;
   logic [2*W-1:0] m_prod = '0;
   logic [2*W-1:0] exp_q [$];
   logic [2*W-1:0] got_q [$];

   always #5 clk = ~clk;

   mult_dispatch #(.W(W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
      .mul_ready(mul_ready), .mul_result(mul_result), .occupancy(occupancy)
   );

   // Multiplier model: latches the product on start, garbage on the result bus until done.
   always @(posedge clk) begin
      if (mul_start) begin
         m_prod     <= (2*W)'(mul_a) * (2*W)'(mul_b);
         m_cnt      <= (lat_cfg > 0) ? lat_cfg : int'($urandom_range(6, 1));
         m_busy     <= 1'b1;
         mul_ready  <= 1'b0;
         mul_result <= (2*W)'($urandom);
      end else if (m_busy) begin
         if (m_cnt <= 1) begin
            mul_ready  <= 1'b1;
            mul_result <= m_prod;
            m_busy     <= 1'b0;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end
   end

   // Expected products in push order, observed products in delivery order.
   always @(posedge clk) begin
      if (mul_start) start_cnt <= start_cnt + 1;
      if (rst_n && in_valid && in_ready) begin
         exp_q.push_back((2*W)'(in_a) * (2*W)'(in_b));
         push_cnt <= push_cnt + 1;
      end
      if (rst_n && out_valid && out_ready) got_q.push_back(out_result);
   end

   task automatic push_pair(input logic [15:0] a, input logic [15:0] b, output bit ok);
      in_a = a; in_b = b; in_valid = 1'b1; ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         if (in_ready) ok = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic drain(output bit ok);
      in_valid = 1'b0; out_ready = 1'b1; ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         if (got_q.size() == exp_q.size() && occupancy == 3'd0 && !out_valid) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({in_ready, out_valid, mul_start, occupancy} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL reset_ctrl: got rdy=%b vld=%b start=%b occ=%0d, want 1 0 0 0", in_ready, out_valid, mul_start, occupancy);
      end
      checks++;
      if ({out_result, mul_a, mul_b} !== 64'd0) begin
         errors++;
         $display("FAIL reset_data: got res=%h a=%h b=%h, want zeros", out_result, mul_a, mul_b);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      bit ok; bit stable; logic [31:0] r; int s0;
      out_ready = 1'b0; lat_cfg = 0; s0 = start_cnt;
      push_pair(16'd3, 16'd5, ok);
      for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
      checks++;
      if (!ok || !out_valid || out_result !== 32'd15) begin
         errors++;
         $display("FAIL basic_result: got vld=%b res=%h, want 1 0000000f", out_valid, out_result);
      end
      r = out_result; stable = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (!out_valid || out_result !== r) stable = 1'b0;
      end
      checks++;
      if (!stable) begin errors++; $display("FAIL basic_hold: got vld=%b res=%h, want held 1 %h", out_valid, out_result, r); end
      checks++;
      if (start_cnt - s0 != 1) begin errors++; $display("FAIL basic_starts: got %0d pulses, want 1", start_cnt - s0); end
      drain(ok);
      checks++;
      if (!ok || got_q.size() != 1) begin errors++; $display("FAIL basic_drain: got %0d results, want 1", got_q.size()); end
      exp_q.delete(); got_q.delete(); out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      bit ok; bit all_ok;
      lat_cfg = 0; out_ready = 1'b1; all_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push_pair(TA[i], TB[i], ok);
         if (!ok) all_ok = 1'b0;
      end
      drain(ok);
      checks++;
      if (!all_ok || !ok || got_q.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d results, want 4", got_q.size()); end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== TE[i]) begin errors++; $display("FAIL b2b_result%0d: got %h, want %h", i, got_q[i], TE[i]); end
      end
      exp_q.delete(); got_q.delete(); out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      bit ok; bit stable; bit prev; logic [31:0] r; logic [31:0] g; logic [31:0] e; int s0; int p0;
      lat_cfg = 3; out_ready = 1'b0;
      push_pair(16'd9, 16'd9, ok);
      for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
      r = out_result; s0 = start_cnt; p0 = push_cnt; stable = out_valid;
      in_a = 16'($urandom); in_b = 16'($urandom); in_valid = 1'b1;
      repeat (50) begin
         prev = in_ready;
         @(negedge clk);
         if (prev) begin in_a = 16'($urandom); in_b = 16'($urandom); end
         if (!out_valid || out_result !== r) stable = 1'b0;
      end
      checks++;
      if (!stable) begin errors++; $display("FAIL bp_hold: got vld=%b res=%h, want 1 %h", out_valid, out_result, r); end
      checks++;
      if (start_cnt != s0) begin errors++; $display("FAIL bp_starts: got %0d extra pulses, want 0", start_cnt - s0); end
      checks++;
      if (occupancy !== 3'd4 || in_ready !== 1'b0 || push_cnt - p0 != 4) begin
         errors++;
         $display("FAIL bp_fill: got occ=%0d rdy=%b pushes=%0d, want 4 0 4", occupancy, in_ready, push_cnt - p0);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (occupancy !== 3'd4 || push_cnt - p0 != 4) begin
         errors++;
         $display("FAIL full_hold: got occ=%0d pushes=%0d, want 4 4", occupancy, push_cnt - p0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      repeat (30) @(negedge clk);
      checks++;
      if (occupancy !== 3'd4 || push_cnt - p0 != 5) begin
         errors++;
         $display("FAIL pop_admit: got occ=%0d pushes=%0d, want 4 5", occupancy, push_cnt - p0);
      end
      drain(ok);
      checks++;
      if (!ok || got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL bp_drain: got %0d results, want %0d", got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if (g !== e) begin errors++; $display("FAIL bp_order: got %h, want %h", g, e); end
      end
      exp_q.delete(); got_q.delete(); out_ready = 1'b0;
   endtask

   task automatic test_zero();
      bit ok1; bit ok2; bit ok; int s0; int want;
`ifdef MULT_DISPATCH_ZERO_BYPASS_EN
      want = 0;
`else
      want = 2;
`endif
      lat_cfg = 2; out_ready = 1'b1; s0 = start_cnt;
      push_pair(16'd0, 16'd7, ok1);
      push_pair(16'h1234, 16'd0, ok2);
      drain(ok);
      checks++;
      if (!ok1 || !ok2 || !ok || got_q.size() != 2) begin errors++; $display("FAIL zero_count: got %0d results, want 2", got_q.size()); end
      for (int i = 0; i < 2 && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== 32'd0) begin errors++; $display("FAIL zero_result%0d: got %h, want 0", i, got_q[i]); end
      end
      checks++;
      if (start_cnt - s0 != want) begin errors++; $display("FAIL zero_starts: got %0d pulses, want %0d", start_cnt - s0, want); end
      exp_q.delete(); got_q.delete(); out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit ok; bit ok2; int s0;
      lat_cfg = 20; out_ready = 1'b1; s0 = start_cnt;
      push_pair(16'd11, 16'd13, ok);
      for (int i = 0; i < 50 && start_cnt == s0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (!ok || {in_ready, out_valid, mul_start, occupancy} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL rst_mid_ctrl: got rdy=%b vld=%b start=%b occ=%0d, want 1 0 0 0", in_ready, out_valid, mul_start, occupancy);
      end
      checks++;
      if ({out_result, mul_a, mul_b} !== 64'd0) begin
         errors++;
         $display("FAIL rst_mid_data: got res=%h a=%h b=%h, want zeros", out_result, mul_a, mul_b);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete(); got_q.delete();
      repeat (30) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || got_q.size() != 0) begin
         errors++;
         $display("FAIL stale_ready: got vld=%b results=%0d, want 0 0", out_valid, got_q.size());
      end
      lat_cfg = 2;
      push_pair(16'd6, 16'd7, ok);
      drain(ok2);
      checks++;
      if (!ok || !ok2 || got_q.size() != 1 || got_q[0] !== 32'd42) begin
         errors++;
         $display("FAIL rst_mid_result: got %0d results first=%h, want 1 0000002a", got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hx);
      end
      exp_q.delete(); got_q.delete(); out_ready = 1'b0;
   endtask

   task automatic test_random();
      bit ok; logic [31:0] g; logic [31:0] e;
      lat_cfg = 0;
      repeat (400) begin
         in_valid  = 1'($urandom);
         in_a      = ($urandom_range(3, 0) == 0) ? 16'd0 : 16'($urandom);
         in_b      = ($urandom_range(3, 0) == 0) ? 16'd0 : 16'($urandom);
         out_ready = 1'($urandom);
         @(negedge clk);
      end
      drain(ok);
      checks++;
      if (!ok || got_q.size() != exp_q.size() || exp_q.size() == 0) begin
         errors++;
         $display("FAIL rand_count: got %0d results, want %0d", got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if (g !== e) begin errors++; $display("FAIL rand_result: got %h, want %h", g, e); end
      end
      exp_q.delete(); got_q.delete(); out_ready = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_zero();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
